mt6835_spi_responder: RTL and testbench
=======================================

Name: mt6835_spi_responder

Overview:
- Synthesizable SPI responder that emulates the MT6835 angle sensor. It is the far end of the SPI link driven by mt6835_spi_reader.
- Used in hardware-in-the-loop and loopback builds. The FOC datapath reads a controllable angle over the real SPI pins without a physical encoder.
- Oversamples CSN/SCK/MOSI in the system clock domain, captures an 8-bit command, and shifts out a 24-bit frame: 8'h00 followed by a 16-bit angle, MSB-first.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on csn/sck/mosi (min 2).
- CMD_BITS, 8, leading frame bits captured from MOSI.
- DATA_BITS, 16, angle width.
- FRAME_BITS, 24, total SCK cycles per frame (= CMD_BITS + DATA_BITS).

Ports:
- clk  in  1  system clock; must be >= 8x SCK frequency.
- rst  in  1  synchronous, active-high reset.
- angle_in  in  DATA_BITS  angle source, sampled once per frame.
- csn  in  1  SPI chip select, active low, asynchronous to clk.
- sck  in  1  SPI clock, idle low, asynchronous to clk.
- mosi  in  1  SPI data from the master, asynchronous to clk.
- miso  out  1  SPI data to the master.
- miso_oe  out  1  1 while selected; top level tri-states miso when 0.
- cmd_rx  out  CMD_BITS  command captured in the last completed frame.
- frame_done  out  1  one-clk pulse when a full frame ends on CSN rise.
- frame_abort  out  1  one-clk pulse when CSN rises before FRAME_BITS SCK rises.

Behaviour:
- Reset values: miso=0, miso_oe=0, cmd_rx=0, frame_done=0, frame_abort=0; state IDLE; bit counter 0.
- Synchronizers: csn, sck and mosi each pass through SYNC_STAGES flops. The csn synchronizer resets to 1; sck and mosi reset to 0.
- Edge detection: registered previous value of each synchronized signal. All events are therefore delayed SYNC_STAGES+1 clk from the pin.
- SPI mode 1 (CPOL=0, CPHA=1):
  - Responder launches miso on each detected SCK rise.
  - Master samples on SCK fall.
  - Responder samples mosi on each detected SCK fall.
- CSN fall (IDLE -> SHIFT):
  - Load shift_tx = {CMD_BITS'0, angle_in} as it is on that clk.
  - Clear bit counter; miso_oe=1; miso=0.
- SHIFT, SCK rise with count < FRAME_BITS: miso <= shift_tx[MSB]; shift_tx shifts left with 0 fill; count+1.
- SHIFT, SCK fall with count <= CMD_BITS: shift mosi into cmd_shift.
- Count reaches FRAME_BITS -> OVERRUN state:
  - Further SCK rises drive miso=0 and are otherwise ignored.
  - No counter wrap.
- CSN rise (from SHIFT or OVERRUN) -> IDLE, with miso_oe=0 and miso=0:
  - If count >= FRAME_BITS: cmd_rx <= cmd_shift and frame_done pulses.
  - Otherwise: frame_abort pulses and cmd_rx is unchanged.
- CSN fall and SCK edge detected on the same clk: the CSN fall wins; the SCK edge is dropped.
- CSN rise and SCK edge on the same clk: the CSN rise wins.
- SCK edges while CSN is high are ignored.
- Angle snapshot happens only at CSN fall. Changes to angle_in mid-frame do not alter the frame in flight.
- rst asserted mid-frame: immediate return to reset values on the next clk; no done or abort pulse.
- frame_done and frame_abort are mutually exclusive and last exactly 1 clk.

Decomposition:
- Shared package mt6835_pkg holds:
  - CMD_BITS, DATA_BITS, FRAME_BITS;
  - the read-angle command constant CMD_RD_ANGLE = 8'hA0;
  - the SPI-mode constants.
  These are shared with mt6835_spi_reader.
- One sub-module, spi_sync_edge: synchronizer plus rise/fall detect, instantiated three times (csn, sck, mosi).

Test Plan:
- Single read: clk 50 MHz, angle_in=16'h1234, master mode 1 at 1 MHz sends 8'hA0 -> master receives 24'h001234; cmd_rx=8'hA0; one frame_done pulse.
- Snapshot: change angle_in from 16'h8000 to 16'hFFFF one SCK after CSN fall -> frame returns 24'h008000; the next frame returns 24'h00FFFF.
- Abort: CSN rises after 10 SCK cycles -> frame_abort pulses once; cmd_rx keeps its prior value; miso_oe=0 within SYNC_STAGES+2 clk.
- Overrun: 30 SCK cycles with angle 16'hFFFF -> bits 25..30 read 0; frame_done pulses at CSN rise.
- Reset mid-frame: rst asserted after 12 SCK cycles -> miso=0 and miso_oe=0 next clk; no pulse; the following full frame is read correctly.
- Loopback with mt6835_spi_reader and angle_in ramped +1 per clk, 100 reads -> every data_out equals angle_in at the registered CSN-fall clk.

Source files
------------

// File: rtl/mt6835_pkg.sv
// rtl/mt6835_pkg.sv - MT6835 SPI frame constants shared by the reader and responder
package mt6835_pkg;

  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = 16;
  localparam int FRAME_BITS = CMD_BITS + DATA_BITS;

  localparam logic [7:0] CMD_RD_ANGLE = 8'hA0;

  // SPI mode 1: SCK idles low, data launched on rise, sampled on fall.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_OVERRUN
  } rsp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pin synchronizer with rise/fall detection
// Ports: clk, rst (sync, active high), din (asynchronous pin),
//        level (synchronized value), rise/fall (one-clk edge strobes).
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mt6835_spi_responder.sv
// rtl/mt6835_spi_responder.sv - MT6835 angle-sensor emulator on an SPI mode-1 link
// Ports: clk, rst (sync, active high), angle_in (snapshot at CSN fall),
//        csn/sck/mosi (asynchronous SPI pins), miso/miso_oe (data and drive enable),
//        cmd_rx (last completed command), frame_done/frame_abort (one-clk pulses).
module mt6835_spi_responder
  import mt6835_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_BITS    = mt6835_pkg::CMD_BITS,
  parameter int DATA_BITS   = mt6835_pkg::DATA_BITS,
  parameter int FRAME_BITS  = CMD_BITS + DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] angle_in,
  input  logic                 csn,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [CMD_BITS-1:0]  cmd_rx,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CMD_CNT   = CW'(CMD_BITS);

  logic csn_lvl, csn_rise, csn_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  // csn idles high so its synchronizer must not manufacture a fall out of reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .rst(rst), .din(csn), .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{csn_lvl, sck_lvl, mosi_rise, mosi_fall};

  rsp_state_t              state, state_n;
  logic [FRAME_BITS-1:0]   shift_tx;
  logic [CMD_BITS-1:0]     cmd_shift;
  logic [CW-1:0]           count;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (csn_fall) state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (csn_rise)                                   state_n = ST_IDLE;
        else if (sck_rise && count == FRAME_CNT - 1'b1) state_n = ST_OVERRUN;
      end
      ST_OVERRUN: if (csn_rise) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // CSN events are tested before SCK edges so they win when both land on one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_tx    <= '0;
      cmd_shift   <= '0;
      cmd_rx      <= '0;
      count       <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (state == ST_IDLE) begin
        if (csn_fall) begin
          shift_tx  <= {{CMD_BITS{1'b0}}, angle_in};
          cmd_shift <= '0;
          count     <= '0;
          miso_oe   <= 1'b1;
          miso      <= 1'b0;
        end
      end else if (csn_rise) begin
        miso_oe <= 1'b0;
        miso    <= 1'b0;
        if (count >= FRAME_CNT) begin
          cmd_rx     <= cmd_shift;
          frame_done <= 1'b1;
        end else begin
          frame_abort <= 1'b1;
        end
      end else if (sck_rise) begin
        if (state == ST_SHIFT && count < FRAME_CNT) begin
          miso     <= shift_tx[FRAME_BITS-1];
          shift_tx <= {shift_tx[FRAME_BITS-2:0], 1'b0};
          count    <= count + 1'b1;
        end else begin
          miso <= 1'b0;
        end
      end else if (sck_fall && state == ST_SHIFT && count <= CMD_CNT) begin
        cmd_shift <= {cmd_shift[CMD_BITS-2:0], mosi_lvl};
      end
    end
  end

endmodule

// File: tb/tb_mt6835_spi_responder.sv
// tb/tb_mt6835_spi_responder.sv - scoreboard bench for mt6835_spi_responder
module tb_mt6835_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] angle_in = '0;
  logic        csn = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, frame_done, frame_abort;
  logic [7:0]  cmd_rx;

  mt6835_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .angle_in(angle_in), .csn(csn), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cmd_rx(cmd_rx),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        done;
    logic [7:0]  cmd;
    logic [31:0] rx;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rx_word = '0;
  logic [7:0]  last_cmd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master side of mode 1: drive mosi on SCK rise, sample miso on SCK fall.
  task automatic spi_bits(input logic [7:0] cmd, input int nbits);
    rx_word = '0;
    csn = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b1;
      mosi = (i < 8) ? cmd[7-i] : 1'b0;
      #HALF;
      sck = 1'b0;
      rx_word = {rx_word[30:0], miso};
      #HALF;
    end
  endtask

  task automatic read_frame(input logic [7:0] cmd, input int nbits, input logic [31:0] exp_rx);
    exp_t e;
    e.done = 1'b1;
    e.cmd  = cmd;
    e.rx   = exp_rx;
    exp_q.push_back(e);
    last_cmd = cmd;
    spi_bits(cmd, nbits);
    csn  = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frame_done || frame_abort)) begin
      check("pulse_exclusive", {31'b0, frame_done & frame_abort}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%b abort=%b expected no pulse", frame_done, frame_abort);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_done", {31'b0, frame_done}, {31'b0, e.done});
        check("cmd_rx", {24'b0, cmd_rx}, {24'b0, e.cmd});
        check("rx_word", rx_word, e.rx);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_miso_oe", {31'b0, miso_oe}, 32'h0);
    check("rst_cmd_rx", {24'b0, cmd_rx}, 32'h0);
    check("rst_done", {31'b0, frame_done}, 32'h0);
    check("rst_abort", {31'b0, frame_abort}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #3;

    angle_in = 16'h1234;
    read_frame(8'hA0, 24, 32'h0000_1234);

    angle_in = 16'h8000;
    fork
      read_frame(8'hA0, 24, 32'h0000_8000);
      begin #(3*HALF); angle_in = 16'hFFFF; end
    join
    read_frame(8'hA0, 24, 32'h0000_FFFF);

    // Abort after 10 clocks: 8 zero bits then the top two angle bits (11).
    angle_in = 16'hC3A5;
    e.done = 1'b0;
    e.cmd  = last_cmd;
    e.rx   = 32'h0000_0003;
    exp_q.push_back(e);
    spi_bits(8'h5A, 10);
    csn  = 1'b1;
    mosi = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    check("abort_miso_oe", {31'b0, miso_oe}, 32'h0);
    check("abort_miso", {31'b0, miso}, 32'h0);
    #(4*HALF);

    // 30 clocks: 24 frame bits then six zeros from the overrun state.
    angle_in = 16'hFFFF;
    read_frame(8'hA0, 30, 32'h003F_FFC0);

    // Reset with CSN low after 12 clocks; the 12th bit launched is angle bit 12 (1).
    spi_bits(8'hA0, 12);
    check("pre_rst_miso", {31'b0, miso}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_miso", {31'b0, miso}, 32'h0);
    check("midrst_miso_oe", {31'b0, miso_oe}, 32'h0);
    csn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_cmd_rx", {24'b0, cmd_rx}, 32'h0);
    rst = 1'b0;
    #(4*HALF);

    angle_in = 16'h5A5A;
    read_frame(8'h3C, 24, 32'h0000_5A5A);
    angle_in = 16'h0001;
    read_frame(8'hA0, 24, 32'h0000_0001);

    #(4*HALF);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
